sa_layer_sequencer: RTL and testbench

Layer-level controller for the systolic-array datapath (scalable_SA → accumulator → reLU). Accepts one layer command at a time and latches its configuration. Sequences the fixed bring-up order: config load, then weight load, then bias load. Then streams input rows into the array and counts result beats from the reLU stage until the layer is complete. It replaces hand-timed testbench stimulus with a reusable, handshaked front end.

---
 rtl/sa_ctrl_pkg.sv | 31 +++
 rtl/sa_layer_sequencer.sv | 205 ++++++++++++++++++++
 tb/tb_sa_layer_sequencer.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sa_ctrl_pkg.sv
// Shared state encoding, opcode constants and latched layer configuration
// for the systolic-array layer sequencer.
package sa_ctrl_pkg;

    localparam logic OP_CONV = 1'b0;
    localparam logic OP_MUL  = 1'b1;

    typedef enum logic [3:0] {
        IDLE,
        CFG,
        GAP_A,
        WLOAD,
        GAP_B,
        BLOAD,
        GAP_C,
        STREAM,
        DRAIN,
        DONE
    } sa_seq_state_t;

    typedef struct packed {
        logic       op_sel;
        logic       relu_sel;
        logic [3:0] w_width;
        logic [3:0] w_height;
        logic [3:0] ifmap_i_w;
        logic [3:0] mul_b_w;
        logic [3:0] mul_b_h;
    } sa_layer_cfg_t;

endpackage

// File: rtl/sa_layer_sequencer.sv
// Layer-level front end for the systolic array: accepts one command, issues the
// config/weight/bias strobes, streams input rows and waits for the result beats.
module sa_layer_sequencer
    import sa_ctrl_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int HEIGHT     = 8,
    parameter int DATA_WIDTH = 8,
    parameter int GAP        = 2,
    parameter int DRAIN_MAX  = 64
) (
    input  logic                        clk,
    input  logic                        nrst,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic                        cmd_op_sel,
    input  logic                        cmd_relu_sel,
    input  logic [3:0]                  cmd_w_width,
    input  logic [3:0]                  cmd_w_height,
    input  logic [3:0]                  cmd_ifmap_i_w,
    input  logic [3:0]                  cmd_mul_b_w,
    input  logic [3:0]                  cmd_mul_b_h,
    input  logic [7:0]                  cmd_rows,
    input  logic [7:0]                  cmd_exp_out,
    output logic                        load_layer_info,
    output logic                        weight_iv,
    output logic                        bias_iv,
    output logic [3:0]                  w_width,
    output logic [3:0]                  w_height,
    output logic [3:0]                  ifmap_i_w,
    output logic [3:0]                  mul_b_w,
    output logic [3:0]                  mul_b_h,
    output logic                        op_sel,
    output logic                        reLU_sel,
    input  logic                        src_valid,
    output logic                        src_ready,
    input  logic [WIDTH*DATA_WIDTH-1:0] src_data,
    output logic                        data_iv,
    output logic [WIDTH*DATA_WIDTH-1:0] data_id,
    input  logic                        conv_ov_re,
    input  logic                        mul_ov_re,
    output logic                        busy,
    output logic                        done,
    output logic                        timeout
);

    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
    localparam int IW = $clog2(DRAIN_MAX + 1);

    if (GAP < 1 || DRAIN_MAX < 1 || HEIGHT < 1) begin : g_param_check
        $error("sa_layer_sequencer: GAP, DRAIN_MAX and HEIGHT must be at least 1");
    end

    sa_seq_state_t state;
    sa_layer_cfg_t cfg;
    logic [7:0]    rows_q;
    logic [7:0]    exp_q;
    logic [7:0]    row_cnt;
    logic [7:0]    res_cnt;
    logic [7:0]    res_cnt_nxt;
    logic [GW-1:0] gap_cnt;
    logic [IW-1:0] idle_cnt;
    logic          res_beat;
    logic          row_beat;
    logic          gap_last;

    // Only the reLU valid matching the latched op is a result beat; beats are
    // counted from the start of streaming so early results are not lost.
    always_comb begin
        res_beat    = (cfg.op_sel == OP_MUL) ? mul_ov_re : conv_ov_re;
        res_cnt_nxt = res_cnt;
        if (res_beat && (res_cnt != 8'hFF) && ((state == STREAM) || (state == DRAIN))) begin
            res_cnt_nxt = res_cnt + 8'd1;
        end
    end

    assign row_beat  = (state == STREAM) && src_valid;
    assign gap_last  = (gap_cnt == GW'(GAP - 1));
    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign src_ready = (state == STREAM);
    assign data_iv   = row_beat;
    assign data_id   = row_beat ? src_data : '0;

    assign op_sel    = cfg.op_sel;
    assign reLU_sel  = cfg.relu_sel;
    assign w_width   = cfg.w_width;
    assign w_height  = cfg.w_height;
    assign ifmap_i_w = cfg.ifmap_i_w;
    assign mul_b_w   = cfg.mul_b_w;
    assign mul_b_h   = cfg.mul_b_h;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state           <= IDLE;
            cfg             <= '0;
            rows_q          <= '0;
            exp_q           <= '0;
            row_cnt         <= '0;
            res_cnt         <= '0;
            gap_cnt         <= '0;
            idle_cnt        <= '0;
            load_layer_info <= 1'b0;
            weight_iv       <= 1'b0;
            bias_iv         <= 1'b0;
            done            <= 1'b0;
            timeout         <= 1'b0;
        end else begin
            load_layer_info <= 1'b0;
            weight_iv       <= 1'b0;
            bias_iv         <= 1'b0;
            done            <= 1'b0;
            res_cnt         <= res_cnt_nxt;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        cfg             <= '{op_sel:    cmd_op_sel,
                                             relu_sel:  cmd_relu_sel,
                                             w_width:   cmd_w_width,
                                             w_height:  cmd_w_height,
                                             ifmap_i_w: cmd_ifmap_i_w,
                                             mul_b_w:   cmd_mul_b_w,
                                             mul_b_h:   cmd_mul_b_h};
                        rows_q          <= cmd_rows;
                        exp_q           <= cmd_exp_out;
                        row_cnt         <= '0;
                        res_cnt         <= '0;
                        idle_cnt        <= '0;
                        timeout         <= 1'b0;
                        load_layer_info <= 1'b1;
                        state           <= CFG;
                    end
                end
                CFG: begin
                    gap_cnt <= '0;
                    state   <= GAP_A;
                end
                GAP_A: begin
                    if (gap_last) begin
                        weight_iv <= 1'b1;
                        state     <= WLOAD;
                    end else begin
                        gap_cnt <= gap_cnt + GW'(1);
                    end
                end
                WLOAD: begin
                    gap_cnt <= '0;
                    state   <= GAP_B;
                end
                GAP_B: begin
                    if (gap_last) begin
                        bias_iv <= 1'b1;
                        state   <= BLOAD;
                    end else begin
                        gap_cnt <= gap_cnt + GW'(1);
                    end
                end
                BLOAD: begin
                    gap_cnt <= '0;
                    state   <= GAP_C;
                end
                GAP_C: begin
                    if (gap_last) begin
                        state <= (rows_q == 8'd0) ? DRAIN : STREAM;
                    end else begin
                        gap_cnt <= gap_cnt + GW'(1);
                    end
                end
                STREAM: begin
                    if (res_beat) begin
                        idle_cnt <= '0;
                    end
                    if (row_beat) begin
                        row_cnt <= row_cnt + 8'd1;
                        if ((row_cnt + 8'd1) == rows_q) begin
                            state <= DRAIN;
                        end
                    end
                end
                // A beat arriving on the expiry cycle wins over the timeout.
                DRAIN: begin
                    if (res_cnt_nxt >= exp_q) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else if (res_beat) begin
                        idle_cnt <= '0;
                    end else if (idle_cnt == IW'(DRAIN_MAX - 1)) begin
                        timeout <= 1'b1;
                        done    <= 1'b1;
                        state   <= DONE;
                    end else begin
                        idle_cnt <= idle_cnt + IW'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sa_layer_sequencer.sv
// Self-checking bench for sa_layer_sequencer: table of back-to-back layers with
// a row scoreboard, plus a hand-written asynchronous reset in the middle of a layer.
module tb_sa_layer_sequencer;
    import sa_ctrl_pkg::*;

    localparam int WIDTH      = 8;
    localparam int HEIGHT     = 8;
    localparam int DATA_WIDTH = 8;
    localparam int GAP        = 2;
    localparam int DRAIN_MAX  = 64;
    localparam int DW         = WIDTH * DATA_WIDTH;
    localparam int S          = 4 + 3 * GAP;

    logic          clk = 1'b0;
    logic          nrst = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_op_sel = 1'b0;
    logic          cmd_relu_sel = 1'b0;
    logic [3:0]    cmd_w_width = '0;
    logic [3:0]    cmd_w_height = '0;
    logic [3:0]    cmd_ifmap_i_w = '0;
    logic [3:0]    cmd_mul_b_w = '0;
    logic [3:0]    cmd_mul_b_h = '0;
    logic [7:0]    cmd_rows = '0;
    logic [7:0]    cmd_exp_out = '0;
    logic          load_layer_info, weight_iv, bias_iv;
    logic [3:0]    w_width, w_height, ifmap_i_w, mul_b_w, mul_b_h;
    logic          op_sel, reLU_sel;
    logic          src_valid = 1'b0;
    logic          src_ready;
    logic [DW-1:0] src_data = '0;
    logic          data_iv;
    logic [DW-1:0] data_id;
    logic          conv_ov_re = 1'b0;
    logic          mul_ov_re = 1'b0;
    logic          busy, done, timeout;

    always #5 clk = ~clk;

    sa_layer_sequencer #(
        .WIDTH(WIDTH), .HEIGHT(HEIGHT), .DATA_WIDTH(DATA_WIDTH),
        .GAP(GAP), .DRAIN_MAX(DRAIN_MAX)
    ) dut (
        .clk(clk), .nrst(nrst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op_sel(cmd_op_sel), .cmd_relu_sel(cmd_relu_sel),
        .cmd_w_width(cmd_w_width), .cmd_w_height(cmd_w_height),
        .cmd_ifmap_i_w(cmd_ifmap_i_w), .cmd_mul_b_w(cmd_mul_b_w), .cmd_mul_b_h(cmd_mul_b_h),
        .cmd_rows(cmd_rows), .cmd_exp_out(cmd_exp_out),
        .load_layer_info(load_layer_info), .weight_iv(weight_iv), .bias_iv(bias_iv),
        .w_width(w_width), .w_height(w_height), .ifmap_i_w(ifmap_i_w),
        .mul_b_w(mul_b_w), .mul_b_h(mul_b_h),
        .op_sel(op_sel), .reLU_sel(reLU_sel),
        .src_valid(src_valid), .src_ready(src_ready), .src_data(src_data),
        .data_iv(data_iv), .data_id(data_id),
        .conv_ov_re(conv_ov_re), .mul_ov_re(mul_ov_re),
        .busy(busy), .done(done), .timeout(timeout)
    );

    typedef struct {
        logic       op;
        logic       relu;
        logic [3:0] ww, wh, iw, bw, bh;
        int         rows;
        int         exp_out;
        int         valid_mode;
        int         beat_start;
        int         beats;
        logic       exp_timeout;
    } vec_t;

    vec_t          vecs[4];
    vec_t          prev_cfg;
    logic          prev_timeout;
    logic [DW-1:0] sb[$];
    int            errors = 0;
    int            checks = 0;

    task automatic check_word(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %b, want %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_cfg(input vec_t e);
        check_bit("op_sel", op_sel, e.op);
        check_bit("reLU_sel", reLU_sel, e.relu);
        check_word("w_width", DW'(w_width), DW'(e.ww));
        check_word("w_height", DW'(w_height), DW'(e.wh));
        check_word("ifmap_i_w", DW'(ifmap_i_w), DW'(e.iw));
        check_word("mul_b_w", DW'(mul_b_w), DW'(e.bw));
        check_word("mul_b_h", DW'(mul_b_h), DW'(e.bh));
    endtask

    function automatic logic src_v(input vec_t v, input int c);
        return (v.valid_mode == 0) ? 1'b1 : (c % 2 == 1);
    endfunction

    function automatic logic beat_on(input vec_t v, input int c);
        return (v.beats > 0) && (c >= v.beat_start) && (c < v.beat_start + 2 * v.beats)
               && ((c - v.beat_start) % 2 == 0);
    endfunction

    task automatic drive_cmd(input vec_t v);
        cmd_op_sel    = v.op;
        cmd_relu_sel  = v.relu;
        cmd_w_width   = v.ww;
        cmd_w_height  = v.wh;
        cmd_ifmap_i_w = v.iw;
        cmd_mul_b_w   = v.bw;
        cmd_mul_b_h   = v.bh;
        cmd_rows      = 8'(v.rows);
        cmd_exp_out   = 8'(v.exp_out);
    endtask

    // Runs one layer from its accept cycle (c=0) to its done cycle; while busy
    // the next layer's command is already offered to exercise the stall.
    task automatic apply_stimulus(input int vi, input int nxt);
        vec_t          v;
        int            d_cyc, done_cyc, n, kc, lb, rows_seen;
        logic          acc, beat;
        logic [DW-1:0] exp_data;
        v = vecs[vi];
        n = 0;
        d_cyc = S;
        if (v.rows > 0) begin
            for (int c = S; c < S + 600; c++) begin
                if (src_v(v, c)) begin
                    n++;
                    if (n == v.rows) begin
                        d_cyc = c + 1;
                        break;
                    end
                end
            end
        end
        if (v.exp_out == 0) begin
            done_cyc = d_cyc + 1;
        end else if (v.beats >= v.exp_out) begin
            kc = v.beat_start + 2 * (v.exp_out - 1);
            done_cyc = ((kc > d_cyc) ? kc : d_cyc) + 1;
        end else begin
            lb = (v.beats > 0) ? v.beat_start + 2 * (v.beats - 1) : -1;
            done_cyc = (lb >= d_cyc) ? lb + DRAIN_MAX + 1 : d_cyc + DRAIN_MAX;
        end
        rows_seen = 0;
        for (int c = 0; c <= done_cyc; c++) begin
            @(posedge clk);
            #1;
            if (c == 0) begin
                drive_cmd(v);
                cmd_valid = 1'b1;
            end else if (nxt >= 0) begin
                drive_cmd(vecs[nxt]);
                cmd_valid = 1'b1;
            end else begin
                cmd_valid = 1'b0;
            end
            src_valid  = src_v(v, c);
            src_data   = {$urandom, $urandom};
            beat       = beat_on(v, c);
            conv_ov_re = (v.op == OP_CONV) ? beat : 1'b1;
            mul_ov_re  = (v.op == OP_MUL) ? beat : 1'b1;
            acc = (rows_seen < v.rows) && (c >= S) && src_valid;
            if (acc) begin
                sb.push_back(src_data);
                rows_seen++;
            end
            #4;
            check_output(v, c, done_cyc, d_cyc, acc);
            if (data_iv === 1'b1) begin
                if (sb.size() > 0) begin
                    exp_data = sb.pop_front();
                    check_word("data_id", data_id, exp_data);
                end else begin
                    check_bit("scoreboard_underflow", data_iv, 1'b0);
                end
            end else begin
                check_word("data_id_bubble", data_id, '0);
            end
        end
        check_word("rows_outstanding", DW'(sb.size()), '0);
        prev_cfg     = v;
        prev_timeout = v.exp_timeout;
    endtask

    task automatic check_output(input vec_t v, input int c, input int done_cyc,
                                input int d_cyc, input logic acc);
        check_bit("cmd_ready", cmd_ready, c == 0);
        check_bit("busy", busy, c != 0);
        check_bit("load_layer_info", load_layer_info, c == 1);
        check_bit("weight_iv", weight_iv, c == 2 + GAP);
        check_bit("bias_iv", bias_iv, c == 3 + 2 * GAP);
        check_bit("done", done, c == done_cyc);
        check_bit("timeout", timeout, (c == 0) ? prev_timeout : (v.exp_timeout && c == done_cyc));
        check_bit("src_ready", src_ready, (v.rows > 0) && (c >= S) && (c < d_cyc));
        check_bit("data_iv", data_iv, acc);
        check_cfg((c == 0) ? prev_cfg : v);
    endtask

    initial begin
        vecs[0] = '{op: OP_CONV, relu: 1'b1, ww: 4'd3, wh: 4'd3, iw: 4'd8, bw: 4'd0, bh: 4'd0,
                    rows: 10, exp_out: 8, valid_mode: 0, beat_start: S + 2, beats: 8, exp_timeout: 1'b0};
        vecs[1] = '{op: OP_MUL, relu: 1'b0, ww: 4'd8, wh: 4'd8, iw: 4'd1, bw: 4'd8, bh: 4'd8,
                    rows: 8, exp_out: 2, valid_mode: 1, beat_start: 30, beats: 2, exp_timeout: 1'b0};
        vecs[2] = '{op: OP_CONV, relu: 1'b0, ww: 4'd2, wh: 4'd4, iw: 4'd5, bw: 4'd1, bh: 4'd2,
                    rows: 3, exp_out: 4, valid_mode: 0, beat_start: S + 2, beats: 2, exp_timeout: 1'b1};
        vecs[3] = '{op: OP_MUL, relu: 1'b1, ww: 4'd1, wh: 4'd1, iw: 4'd1, bw: 4'd3, bh: 4'd5,
                    rows: 0, exp_out: 0, valid_mode: 0, beat_start: 0, beats: 0, exp_timeout: 1'b0};
        prev_cfg     = '{default: 0};
        prev_timeout = 1'b0;

        #22;
        check_bit("reset_cmd_ready", cmd_ready, 1'b1);
        check_bit("reset_busy", busy, 1'b0);
        check_bit("reset_done", done, 1'b0);
        check_bit("reset_timeout", timeout, 1'b0);
        check_bit("reset_load_layer_info", load_layer_info, 1'b0);
        check_bit("reset_data_iv", data_iv, 1'b0);
        check_word("reset_data_id", data_id, '0);
        check_cfg(prev_cfg);
        #1 nrst = 1'b1;

        for (int i = 0; i < 4; i++) begin
            apply_stimulus(i, (i < 3) ? i + 1 : -1);
        end

        // Abandon a layer mid-stream with an asynchronous reset.
        for (int c = 0; c <= S + 2; c++) begin
            @(posedge clk);
            #1;
            if (c == 0) begin
                drive_cmd(vecs[0]);
                cmd_valid = 1'b1;
            end else begin
                cmd_valid = 1'b0;
            end
            src_valid  = 1'b1;
            src_data   = {$urandom, $urandom};
            conv_ov_re = 1'b0;
            mul_ov_re  = 1'b0;
            #4;
        end
        check_bit("pre_reset_data_iv", data_iv, 1'b1);
        check_bit("pre_reset_busy", busy, 1'b1);
        #2 nrst = 1'b0;
        #1;
        check_bit("mid_reset_data_iv", data_iv, 1'b0);
        check_bit("mid_reset_busy", busy, 1'b0);
        check_word("mid_reset_data_id", data_id, '0);
        check_word("mid_reset_w_width", DW'(w_width), '0);
        check_word("mid_reset_ifmap_i_w", DW'(ifmap_i_w), '0);
        check_bit("mid_reset_reLU_sel", reLU_sel, 1'b0);
        #3 nrst = 1'b1;
        #1;
        check_bit("post_reset_cmd_ready", cmd_ready, 1'b1);
        check_bit("post_reset_done", done, 1'b0);
        sb.delete();
        prev_cfg     = '{default: 0};
        prev_timeout = 1'b0;
        apply_stimulus(3, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
